// File: rtl/vram_pkg.sv
// vram_pkg -- shared definitions for the VRAM arbiter slice.
//   VRAM_AW / VRAM_DW : default VRAM address / data widths
//   state_t           : arbiter FSM encoding (IDLE, ISSUE, WAIT, DONE)
//   owner_t           : which requester owns the access in flight
package vram_pkg;

  localparam int VRAM_AW = 24;
  localparam int VRAM_DW = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef enum logic {
    OWN_VID = 1'b0,
    OWN_CPU = 1'b1
  } owner_t;

endpackage

// File: rtl/vram_arbiter_if.sv
// vram_arbiter_if -- bundles the video requester, CPU requester and external
// VRAM buses that meet at the arbiter.
//   slave  : arbiter side (samples requests and VRAM read data, drives acks and VRAM strobes)
//   master : environment side (requesters plus the VRAM device)
interface vram_arbiter_if
  import vram_pkg::*;
#(
  parameter int AW = VRAM_AW,
  parameter int DW = VRAM_DW
);

  // video fetch path
  logic          i_vid_req;
  logic [AW-1:0] i_vid_addr;
  logic          o_vid_ack;
  logic [DW-1:0] o_vid_data;
  // CPU / host path
  logic          i_cpu_req;
  logic          i_cpu_we;
  logic [AW-1:0] i_cpu_addr;
  logic [DW-1:0] i_cpu_wdata;
  logic          o_cpu_ack;
  logic [DW-1:0] o_cpu_rdata;
  // external VRAM
  logic [AW-1:0] o_vram_addr;
  logic          o_vram_en;
  logic          o_vram_we;
  logic [DW-1:0] o_vram_wdata;
  logic [DW-1:0] i_vram_data;
  // status
  logic          o_busy;

  modport slave (
    input  i_vid_req, i_vid_addr, i_cpu_req, i_cpu_we, i_cpu_addr, i_cpu_wdata, i_vram_data,
    output o_vid_ack, o_vid_data, o_cpu_ack, o_cpu_rdata,
           o_vram_addr, o_vram_en, o_vram_we, o_vram_wdata, o_busy
  );

  modport master (
    output i_vid_req, i_vid_addr, i_cpu_req, i_cpu_we, i_cpu_addr, i_cpu_wdata, i_vram_data,
    input  o_vid_ack, o_vid_data, o_cpu_ack, o_cpu_rdata,
           o_vram_addr, o_vram_en, o_vram_we, o_vram_wdata, o_busy
  );

endinterface

// File: rtl/vram_arb_pick.sv
// vram_arb_pick -- combinational grant selection.
//   vid_req     : video request pending
//   cpu_req     : CPU request pending
//   cpu_starved : CPU has waited long enough to beat a pending video request
//   grant       : some request can be granted this cycle
//   owner       : requester that wins
module vram_arb_pick
  import vram_pkg::*;
(
  input  logic   vid_req,
  input  logic   cpu_req,
  input  logic   cpu_starved,
  output logic   grant,
  output owner_t owner
);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    grant = vid_req | cpu_req;
    owner = OWN_VID;
    // Video has priority unless the CPU counter has saturated.
    if (cpu_req && (!vid_req || cpu_starved)) owner = OWN_CPU;
  end

endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter -- shares a single-port byte-wide VRAM between the VGA
// character/attribute fetch (video) and the CPU/host path. Video has priority;
// a saturating starvation counter guarantees the CPU a slot. One access in
// flight at a time: grant in IDLE, strobe in ISSUE, RD_LAT cycles in WAIT,
// ack pulse in DONE.
//   i_clk   : system clock
//   i_reset : asynchronous reset, active-high
//   bus     : requester + VRAM signals (vram_arbiter_if.slave)
// Parameters: AW/DW widths, RD_LAT VRAM read latency (1..4), STARVE CPU wait
// limit in cycles (1..15).
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int AW     = VRAM_AW,
  parameter int DW     = VRAM_DW,
  parameter int RD_LAT = 1,
  parameter int STARVE = 4
) (
  input logic           i_clk,
  input logic           i_reset,
  vram_arbiter_if.slave bus
);

  localparam logic [1:0] LAT_LOAD   = 2'(RD_LAT - 1);
  localparam logic [3:0] STARVE_MAX = 4'(STARVE);

  state_t        state;
  owner_t        owner;
  logic          acc_we;      // write flag of the access in flight
  logic [1:0]    lat_cnt;
  logic [3:0]    starve_cnt;

  logic          pick_grant;
  owner_t        pick_owner;
  logic          cpu_starved;
  logic          cpu_granted;
  logic          cpu_in_flight;
  logic [AW-1:0] grant_addr;
  logic [DW-1:0] grant_wdata;

  assign cpu_starved = (starve_cnt == STARVE_MAX);

  vram_arb_pick u_pick (
    .vid_req     (bus.i_vid_req),
    .cpu_req     (bus.i_cpu_req),
    .cpu_starved (cpu_starved),
    .grant       (pick_grant),
    .owner       (pick_owner)
  );

  assign cpu_granted   = (state == IDLE) && pick_grant && (pick_owner == OWN_CPU);
  assign cpu_in_flight = (state != IDLE) && (owner == OWN_CPU);
  assign grant_addr    = (pick_owner == OWN_CPU) ? bus.i_cpu_addr : bus.i_vid_addr;
  // Video grants keep the previous write data; it is never strobed with we=1.
  assign grant_wdata   = (pick_owner == OWN_CPU) ? bus.i_cpu_wdata : bus.o_vram_wdata;
  assign bus.o_busy    = (state != IDLE);

  // The VRAM address/we/wdata registers double as the grant latches: they are
  // loaded on the IDLE->ISSUE edge, so they are valid exactly while en is high
  // and simply hold afterwards.
  // NOTE: async reset is in the sensitivity list so outputs clear the instant reset asserts, even mid-access.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state            <= IDLE;
      owner            <= OWN_VID;
      acc_we           <= 1'b0;
      lat_cnt          <= 2'd0;
      bus.o_vram_en    <= 1'b0;
      bus.o_vram_we    <= 1'b0;
      bus.o_vram_addr  <= '0;
      bus.o_vram_wdata <= '0;
      bus.o_vid_ack    <= 1'b0;
      bus.o_vid_data   <= '0;
      bus.o_cpu_ack    <= 1'b0;
      bus.o_cpu_rdata  <= '0;
    end else begin
      // NOTE: non-blocking everywhere here so each flop sees pre-edge values; these
      // defaults make every strobe and ack a single-cycle pulse.
      bus.o_vram_en <= 1'b0;
      bus.o_vram_we <= 1'b0;
      bus.o_vid_ack <= 1'b0;
      bus.o_cpu_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_grant) begin
            owner            <= pick_owner;
            acc_we           <= (pick_owner == OWN_CPU) && bus.i_cpu_we;
            bus.o_vram_addr  <= grant_addr;
            bus.o_vram_wdata <= grant_wdata;
            bus.o_vram_we    <= (pick_owner == OWN_CPU) && bus.i_cpu_we;
            bus.o_vram_en    <= 1'b1;
            state            <= ISSUE;
          end
        end
        ISSUE: begin
          lat_cnt <= LAT_LOAD;
          state   <= WAIT;
        end
        WAIT: begin
          if (lat_cnt == 2'd0) begin
            if (owner == OWN_CPU) begin
              if (!acc_we) bus.o_cpu_rdata <= bus.i_vram_data;
              bus.o_cpu_ack <= 1'b1;
            end else begin
              bus.o_vid_data <= bus.i_vram_data;
              bus.o_vid_ack  <= 1'b1;
            end
            state <= DONE;
          end else begin
            lat_cnt <= lat_cnt - 2'd1;
          end
        end
        DONE: state <= IDLE;
      endcase
    end
  end

  // Counts cycles a CPU request is pending but not yet granted; holding while
  // the CPU's own access is in flight keeps that access from counting as waiting.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      starve_cnt <= 4'd0;
    end else if (!bus.i_cpu_req || cpu_granted) begin
      starve_cnt <= 4'd0;
    end else if (!cpu_in_flight && (starve_cnt != STARVE_MAX)) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter -- scoreboard bench for vram_arbiter. Stimulus pushes the
// expected VRAM strobes and acks (hand-computed cycles and data) into queues;
// a negedge monitor pops and compares whenever the DUT presents them.
// Two instances: dut (RD_LAT=1, STARVE=4) and dut3 (RD_LAT=3, STARVE=4).
module tb_vram_arbiter;
  import vram_pkg::*;

  localparam int AW = 24;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  vram_arbiter_if #(.AW(AW), .DW(DW)) bus1 ();
  vram_arbiter_if #(.AW(AW), .DW(DW)) bus3 ();

  vram_arbiter #(.AW(AW), .DW(DW), .RD_LAT(1), .STARVE(4)) dut (
    .i_clk(clk), .i_reset(rst), .bus(bus1)
  );
  vram_arbiter #(.AW(AW), .DW(DW), .RD_LAT(3), .STARVE(4)) dut3 (
    .i_clk(clk), .i_reset(rst), .bus(bus3)
  );

  // ---------------- VRAM model: fixed contents + written overlay ----------
  logic [7:0]   mem [0:255];
  logic [255:0] written;
  logic [8:0]   pipe1 [0:3];   // {valid, data}
  logic [8:0]   pipe3 [0:3];

  function automatic logic [7:0] rom(input logic [23:0] a);
    case (a)
      24'h000123: rom = 8'h41;
      24'h000200: rom = 8'h11;
      24'h000300: rom = 8'h22;
      24'h000400: rom = 8'h33;
      24'h000500: rom = 8'h44;
      24'h000600: rom = 8'h7E;
      24'h000700: rom = 8'h55;
      default:    rom = 8'h00;
    endcase
  endfunction

  // Test addresses are distinct in bits [11:4].
  function automatic logic [7:0] vram_read(input logic [23:0] a);
    vram_read = written[a[11:4]] ? mem[a[11:4]] : rom(a);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      written <= '0;
    end else if (bus1.o_vram_en && bus1.o_vram_we) begin
      mem[bus1.o_vram_addr[11:4]]     <= bus1.o_vram_wdata;
      written[bus1.o_vram_addr[11:4]] <= 1'b1;
    end
    pipe1[0] <= {bus1.o_vram_en && !bus1.o_vram_we, vram_read(bus1.o_vram_addr)};
    pipe3[0] <= {bus3.o_vram_en && !bus3.o_vram_we, vram_read(bus3.o_vram_addr)};
    for (int i = 1; i < 4; i++) begin
      pipe1[i] <= pipe1[i-1];
      pipe3[i] <= pipe3[i-1];
    end
  end

  // Read data is only meaningful in the one cycle RD_LAT after the strobe.
  assign bus1.i_vram_data = pipe1[0][8] ? pipe1[0][7:0] : 8'hEE;
  assign bus3.i_vram_data = pipe3[2][8] ? pipe3[2][7:0] : 8'hEE;

  // ---------------- scoreboard ---------------------------------------------
  typedef struct {
    owner_t     own;
    logic [7:0] data;
    int         at;
  } ack_exp_t;

  typedef struct {
    logic [23:0] addr;
    logic        we;
    logic [7:0]  wdata;
    int          at;
  } stb_exp_t;

  ack_exp_t ack_q1[$];
  ack_exp_t ack_q3[$];
  stb_exp_t stb_q1[$];
  stb_exp_t stb_q3[$];

  task automatic flag(input string name, input string act, input string exp);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got %s, expected %s", name, act, exp);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
    end
  endtask

  task automatic mon_ack(input int inst, input logic va, input logic ca,
                         input logic [7:0] vd, input logic [7:0] cd);
    ack_exp_t e;
    string    p;
    p = (inst == 1) ? "L1" : "L3";
    if (!(va || ca)) return;
    if (va && ca) flag({p, "_dual_ack"}, "both acks", "one ack");
    if ((inst == 1 && ack_q1.size() == 0) || (inst == 3 && ack_q3.size() == 0)) begin
      flag({p, "_unexpected_ack"}, $sformatf("ack at cycle %0d", cyc), "no ack");
      return;
    end
    if (inst == 1) e = ack_q1.pop_front();
    else           e = ack_q3.pop_front();
    check({p, "_ack_owner"}, 32'(ca), 32'(e.own));
    check({p, "_ack_data"},  32'(ca ? cd : vd), 32'(e.data));
    check({p, "_ack_cycle"}, 32'(cyc), 32'(e.at));
  endtask

  task automatic mon_stb(input int inst, input logic en, input logic we,
                         input logic [23:0] addr, input logic [7:0] wdata);
    stb_exp_t e;
    string    p;
    p = (inst == 1) ? "L1" : "L3";
    if (!en && we) flag({p, "_we_without_en"}, "we=1 en=0", "we=0");
    if (!en) return;
    if ((inst == 1 && stb_q1.size() == 0) || (inst == 3 && stb_q3.size() == 0)) begin
      flag({p, "_unexpected_strobe"}, $sformatf("en at cycle %0d", cyc), "no strobe");
      return;
    end
    if (inst == 1) e = stb_q1.pop_front();
    else           e = stb_q3.pop_front();
    check({p, "_stb_addr"},  32'(addr), 32'(e.addr));
    check({p, "_stb_we"},    32'(we),   32'(e.we));
    check({p, "_stb_cycle"}, 32'(cyc),  32'(e.at));
    if (e.we) check({p, "_stb_wdata"}, 32'(wdata), 32'(e.wdata));
  endtask

  always @(negedge clk) begin
    mon_ack(1, bus1.o_vid_ack, bus1.o_cpu_ack, bus1.o_vid_data, bus1.o_cpu_rdata);
    mon_ack(3, bus3.o_vid_ack, bus3.o_cpu_ack, bus3.o_vid_data, bus3.o_cpu_rdata);
    mon_stb(1, bus1.o_vram_en, bus1.o_vram_we, bus1.o_vram_addr, bus1.o_vram_wdata);
    mon_stb(3, bus3.o_vram_en, bus3.o_vram_we, bus3.o_vram_addr, bus3.o_vram_wdata);
  end

  // ---------------- stimulus helpers ---------------------------------------
  function automatic logic ack_of(input int inst, input bit cpu);
    if (inst == 1) ack_of = cpu ? bus1.o_cpu_ack : bus1.o_vid_ack;
    else           ack_of = cpu ? bus3.o_cpu_ack : bus3.o_vid_ack;
  endfunction

  task automatic wait_ack(input int inst, input bit cpu, input int n, input string name);
    int seen;
    seen = 0;
    for (int k = 0; k < 60 && seen < n; k++) begin
      @(negedge clk);
      if (ack_of(inst, cpu)) seen++;
    end
    if (seen < n) flag({name, "_timeout"}, $sformatf("%0d acks", seen), $sformatf("%0d acks", n));
  endtask

  task automatic wait_cycle(input int target);
    for (int k = 0; k < 60 && cyc < target; k++) @(negedge clk);
  endtask

  // Single access on instance 1, started in an IDLE cycle; returns in the next IDLE cycle.
  task automatic vid_access(input logic [23:0] addr, input logic [7:0] exp, input string name);
    int t0;
    t0 = cyc;
    stb_q1.push_back('{addr, 1'b0, 8'h00, t0 + 1});
    ack_q1.push_back('{OWN_VID, exp, t0 + 3});
    bus1.i_vid_req  = 1'b1;
    bus1.i_vid_addr = addr;
    wait_ack(1, 1'b0, 1, name);
    bus1.i_vid_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic cpu_access(input logic [23:0] addr, input logic we, input logic [7:0] wdata,
                            input logic [7:0] exp, input string name);
    int t0;
    t0 = cyc;
    stb_q1.push_back('{addr, we, wdata, t0 + 1});
    ack_q1.push_back('{OWN_CPU, exp, t0 + 3});
    bus1.i_cpu_req   = 1'b1;
    bus1.i_cpu_we    = we;
    bus1.i_cpu_addr  = addr;
    bus1.i_cpu_wdata = wdata;
    wait_ack(1, 1'b1, 1, name);
    bus1.i_cpu_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string p);
    check({p, "_vid_ack"},    32'(bus1.o_vid_ack),    0);
    check({p, "_vid_data"},   32'(bus1.o_vid_data),   0);
    check({p, "_cpu_ack"},    32'(bus1.o_cpu_ack),    0);
    check({p, "_cpu_rdata"},  32'(bus1.o_cpu_rdata),  0);
    check({p, "_vram_addr"},  32'(bus1.o_vram_addr),  0);
    check({p, "_vram_en"},    32'(bus1.o_vram_en),    0);
    check({p, "_vram_we"},    32'(bus1.o_vram_we),    0);
    check({p, "_vram_wdata"}, 32'(bus1.o_vram_wdata), 0);
    check({p, "_busy"},       32'(bus1.o_busy),       0);
  endtask

  // ---------------- directed sequence --------------------------------------
  initial begin
    int t0;
    bus1.i_vid_req = 1'b0; bus1.i_vid_addr = '0;
    bus1.i_cpu_req = 1'b0; bus1.i_cpu_we = 1'b0; bus1.i_cpu_addr = '0; bus1.i_cpu_wdata = '0;
    bus3.i_vid_req = 1'b0; bus3.i_vid_addr = '0;
    bus3.i_cpu_req = 1'b0; bus3.i_cpu_we = 1'b0; bus3.i_cpu_addr = '0; bus3.i_cpu_wdata = '0;

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    check("reset_starve", 32'(dut.starve_cnt), 0);
    check("reset_l3_busy", 32'(bus3.o_busy), 0);
    rst = 1'b0;
    @(negedge clk);

    // Video-only read and CPU write / read-back, RD_LAT=1.
    vid_access(24'h000123, 8'h41, "t1_vid_read");
    cpu_access(24'h000010, 1'b1, 8'hA5, 8'h00, "t2_cpu_write");   // rdata untouched by a write
    cpu_access(24'h000010, 1'b0, 8'h00, 8'hA5, "t2_cpu_readback");

    // Video held back-to-back, CPU raised one cycle later: vid, vid, cpu, vid.
    t0 = cyc;
    stb_q1.push_back('{24'h000200, 1'b0, 8'h00, t0 + 1});
    stb_q1.push_back('{24'h000200, 1'b0, 8'h00, t0 + 5});
    stb_q1.push_back('{24'h000300, 1'b0, 8'h00, t0 + 9});
    stb_q1.push_back('{24'h000200, 1'b0, 8'h00, t0 + 13});
    ack_q1.push_back('{OWN_VID, 8'h11, t0 + 3});
    ack_q1.push_back('{OWN_VID, 8'h11, t0 + 7});
    ack_q1.push_back('{OWN_CPU, 8'h22, t0 + 11});
    ack_q1.push_back('{OWN_VID, 8'h11, t0 + 15});
    bus1.i_vid_req  = 1'b1;
    bus1.i_vid_addr = 24'h000200;
    @(negedge clk);
    bus1.i_cpu_req  = 1'b1;
    bus1.i_cpu_we   = 1'b0;
    bus1.i_cpu_addr = 24'h000300;
    fork
      begin
        wait_ack(1, 1'b0, 3, "t3_vid");
        bus1.i_vid_req = 1'b0;
      end
      begin
        wait_ack(1, 1'b1, 1, "t3_cpu");
        bus1.i_cpu_req = 1'b0;
      end
      begin
        wait_cycle(t0 + 7);
        check("t3_starve_saturated", 32'(dut.starve_cnt), 4);
        wait_cycle(t0 + 9);
        check("t3_starve_cleared", 32'(dut.starve_cnt), 0);
      end
    join
    @(negedge clk);

    // Both raised together with starve_cnt=0: video first, CPU next IDLE.
    t0 = cyc;
    stb_q1.push_back('{24'h000400, 1'b0, 8'h00, t0 + 1});
    stb_q1.push_back('{24'h000500, 1'b0, 8'h00, t0 + 5});
    ack_q1.push_back('{OWN_VID, 8'h33, t0 + 3});
    ack_q1.push_back('{OWN_CPU, 8'h44, t0 + 7});
    bus1.i_vid_req  = 1'b1;
    bus1.i_vid_addr = 24'h000400;
    bus1.i_cpu_req  = 1'b1;
    bus1.i_cpu_we   = 1'b0;
    bus1.i_cpu_addr = 24'h000500;
    fork
      begin
        wait_ack(1, 1'b0, 1, "t4_vid");
        bus1.i_vid_req = 1'b0;
      end
      begin
        wait_ack(1, 1'b1, 1, "t4_cpu");
        bus1.i_cpu_req = 1'b0;
      end
    join
    @(negedge clk);

    // RD_LAT=3 CPU read: ack at cycle 5.
    t0 = cyc;
    stb_q3.push_back('{24'h000600, 1'b0, 8'h00, t0 + 1});
    ack_q3.push_back('{OWN_CPU, 8'h7E, t0 + 5});
    bus3.i_cpu_req  = 1'b1;
    bus3.i_cpu_we   = 1'b0;
    bus3.i_cpu_addr = 24'h000600;
    wait_ack(3, 1'b1, 1, "t5_lat3");
    bus3.i_cpu_req = 1'b0;
    @(negedge clk);

    // Reset during WAIT: outputs clear at once, no ack, no further strobe.
    t0 = cyc;
    stb_q1.push_back('{24'h000700, 1'b0, 8'h00, t0 + 1});
    bus1.i_vid_req  = 1'b1;
    bus1.i_vid_addr = 24'h000700;
    repeat (2) @(negedge clk);
    check("t6_in_wait", 32'(dut.state), 32'(WAIT));
    rst = 1'b1;
    #1;
    check_all_zero("t6_reset");
    bus1.i_vid_req = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    vid_access(24'h000123, 8'h41, "t6_after_reset");

    repeat (4) @(negedge clk);
    check("ack_q1_drained", 32'(ack_q1.size()), 0);
    check("stb_q1_drained", 32'(stb_q1.size()), 0);
    check("ack_q3_drained", 32'(ack_q3.size()), 0);
    check("stb_q3_drained", 32'(stb_q3.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares the single-port, byte-wide VRAM between two requesters: the VGA character/attribute fetch path (video) and the CPU/host access path (cpu).
- Sits between the VGA controller's VRAM address/data bus and the external VRAM.
- Video has priority so the display meets its deadlines. A starvation counter guarantees the CPU a slot within a bounded time.
- One access is in flight at a time. Each access gets a registered address/strobe and a registered data/ack return.

Parameters:
- AW, 24, VRAM address width.
- DW, 8, VRAM data width.
- RD_LAT, 1, VRAM synchronous read latency in cycles (1..4).
- STARVE, 4, number of consecutive cycles an un-granted CPU request must wait before it beats a pending video request (1..15).

Ports:
- i_clk  in  1  system clock.
- i_reset  in  1  asynchronous reset, active-high.
- i_vid_req  in  1  video read request; held until o_vid_ack.
- i_vid_addr  in  AW  video read address.
- o_vid_ack  out  1  one-cycle pulse; o_vid_data is valid in the same cycle.
- o_vid_data  out  DW  video read data, held until the next video ack.
- i_cpu_req  in  1  CPU request; held until o_cpu_ack.
- i_cpu_we  in  1  CPU write enable.
- i_cpu_addr  in  AW  CPU address.
- i_cpu_wdata  in  DW  CPU write data.
- o_cpu_ack  out  1  one-cycle completion pulse.
- o_cpu_rdata  out  DW  CPU read data (valid with ack on reads; unchanged on writes).
- o_vram_addr  out  AW  VRAM address.
- o_vram_en  out  1  VRAM access strobe, one cycle per access.
- o_vram_we  out  1  VRAM write strobe (only with o_vram_en).
- o_vram_wdata  out  DW  VRAM write data.
- i_vram_data  in  DW  VRAM read data, valid RD_LAT cycles after o_vram_en.
- o_busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset: all outputs are 0, the FSM goes to IDLE, the starvation counter is 0, and the owner is video.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - No request: remain in IDLE.
  - Only one request pending: grant it.
  - Both pending: grant cpu if starve_cnt == STARVE, otherwise grant video.
  - On a grant: latch the owner, address, we and wdata (we is forced to 0 for video), then go to ISSUE.
- ISSUE: o_vram_en = 1 for exactly one cycle, with o_vram_addr, o_vram_we and o_vram_wdata driven from the latches. Next state is WAIT with lat_cnt = RD_LAT-1.
- WAIT: decrement lat_cnt. When lat_cnt == 0, capture i_vram_data into the owner's data register (reads only) and go to DONE.
- DONE: pulse the owner's ack for one cycle, then return to IDLE.
- Latency: a request first seen in IDLE at cycle 0 has o_vram_en at cycle 1, data captured at cycle 1+RD_LAT, and ack at cycle 2+RD_LAT. Writes use the same timing.
- Minimum spacing between grants is 3+RD_LAT cycles.
- Requester rule: drop req on the cycle after ack, or keep it asserted with new addr/data to issue a back-to-back request. A req still high in the IDLE cycle after DONE is treated as a new request.
- Request stability: addr, we and wdata must be stable while req is high. The arbiter samples them only on grant, so changes after grant are ignored.
- starve_cnt (4-bit, saturating at STARVE):
  - Increments every cycle that i_cpu_req is high and the cpu is not being granted.
  - Clears on a cpu grant.
  - Is forced to 0 while i_cpu_req is low.
- Simultaneous requests: video wins unless starve_cnt == STARVE, so at most one video access intervenes once the counter is saturated.
- Outside ISSUE: o_vram_en and o_vram_we are 0; o_vram_addr and o_vram_wdata hold their last values.
- Reset mid-access: the access is abandoned, no ack is issued, and no VRAM strobe is produced after reset asserts.

Decomposition:
- Shared package vram_pkg:
  - AW/DW defaults.
  - State encoding localparams: IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, DONE=2'd3.
  - Owner encoding: OWN_VID=1'b0, OWN_CPU=1'b1.
- One sub-module, vram_arb_pick: combinational grant selection from (vid_req, cpu_req, starve_cnt == STARVE).
- Everything else stays in the top module.

Test Plan:
- Video-only read, RD_LAT=1, i_vid_addr=24'h000123, VRAM returns 8'h41 → o_vram_en at cycle 1 with addr 24'h000123 and we=0; o_vid_ack and o_vid_data=8'h41 at cycle 3.
- CPU write, addr 24'h000010, wdata 8'hA5 → o_vram_en=o_vram_we=1 with wdata 8'hA5 at cycle 1; o_cpu_ack at cycle 3; o_cpu_rdata unchanged.
- i_vid_req held continuously (back-to-back) and CPU read request raised, STARVE=4 → the first video access completes, then at most one more video grant, then a cpu grant; starve_cnt=0 after the cpu grant.
- Both requests raised in the same cycle with starve_cnt=0 → video is granted first, the cpu on the next IDLE; no cycle has o_vram_en high in both accesses' windows.
- RD_LAT=3, cpu read returning 8'h7E → ack at cycle 5 with o_cpu_rdata=8'h7E.
- i_reset asserted during WAIT → all outputs 0 immediately, no ack; after deassert, a new video request completes normally.
